// File: rtl/decrypt_checker.sv
// -----------------------------------------------------------------------------
// decrypt_checker
//   Plaintext validity checker placed after the RC4 decrypt stage. A `start`
//   pulse in IDLE makes it walk the decrypted-message RAM from address 0 up to
//   MESSAGE_LENGTH-1. It checks that every byte is a lowercase ASCII letter
//   (8'h61..8'h7A) or a space (8'h20). It stops at the first illegal byte.
//   The result stays on `valid`/`fail_index` until the next accepted start.
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   request a check; looked at only in IDLE
//   q[7:0]      in   RAM read data, valid one cycle after `address` is sampled
//   address[7:0]out  RAM read address; forced to 0 outside READ/WAIT/CHECK
//   finish      out  one-cycle pulse in DONE
//   valid       out  1 = every byte of the last check was legal
//   fail_index  out  address of the first illegal byte, 0 on pass
//   busy        out  high in every state except IDLE
// -----------------------------------------------------------------------------
module decrypt_checker #(
  parameter int MESSAGE_LENGTH = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] q,
  output logic [7:0] address,
  output logic       finish,
  output logic       valid,
  output logic [7:0] fail_index,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Terminal index. With MESSAGE_LENGTH=256 this is 255, so the 8-bit index
  // never has to wrap during one check.
  localparam logic [7:0] LAST_IDX = 8'(MESSAGE_LENGTH - 1);

  logic [2:0] state, state_nxt;
  logic [7:0] idx;
  logic       byte_ok;
  logic       rd_phase;

  assign byte_ok = (q == 8'h20) || ((q >= 8'h61) && (q <= 8'h7A));

  // The address reaches a shared OR bus, so it must be 0 whenever the
  // checker is not actively reading.
  assign rd_phase = (state == S_READ) || (state == S_WAIT) || (state == S_CHECK);
  assign address  = rd_phase ? idx : 8'h00;
  assign finish   = (state == S_DONE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  state_nxt = S_WAIT;
      // WAIT covers the RAM's registered address; q becomes valid in CHECK.
      S_WAIT:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (!byte_ok || (idx == LAST_IDX)) state_nxt = S_DONE;
        else                               state_nxt = S_READ;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      idx        <= 8'h00;
      valid      <= 1'b0;
      fail_index <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx        <= 8'h00;
            valid      <= 1'b0;
            fail_index <= 8'h00;
          end
        end
        S_CHECK: begin
          // The result is registered on the edge that enters DONE. It is
          // therefore already stable while `finish` is high.
          if (!byte_ok) begin
            valid      <= 1'b0;
            fail_index <= idx;
          end else if (idx == LAST_IDX) begin
            valid      <= 1'b1;
            fail_index <= 8'h00;
          end else begin
            idx <= idx + 8'h01;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
